// File: rtl/alu.sv
// Registered 8-bit arithmetic/compare unit with a 16-bit result and one cycle of latency.
// Divide and remainder come from a combinational unrolled restoring array.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [2:0]           opcode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result
);

    localparam int RW = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_EQ  = 3'b101,
        OP_GT  = 3'b110,
        OP_LT  = 3'b111
    } op_t;

    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [RW-1:0]    next_result;

    assign a_ext = {{WIDTH{1'b0}}, a};
    assign b_ext = {{WIDTH{1'b0}}, b};

    // Restoring division: each stage shifts in one dividend bit (MSB first)
    // and subtracts b when the partial remainder is large enough. The partial
    // remainder is always < b, so the shifted value needs only WIDTH+1 bits.
    logic [WIDTH-1:0] rem_stage [0:WIDTH];
    assign rem_stage[0] = '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_div
        logic [WIDTH:0] partial;
        logic [WIDTH:0] diff;
        logic           fits;

        assign partial = {rem_stage[i], a[WIDTH-1-i]};
        assign fits    = (partial >= {1'b0, b});
        assign diff    = partial - {1'b0, b};

        assign quotient[WIDTH-1-i] = fits;
        assign rem_stage[i+1]      = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end

    assign remainder = rem_stage[WIDTH];

    always_comb begin
        next_result = '0;
        if (ena) begin
            case (op_t'(opcode))
                OP_ADD: next_result = a_ext + b_ext;
                OP_SUB: next_result = a_ext - b_ext;
                OP_MUL: next_result = a_ext * b_ext;
                OP_DIV: begin
                    if (b == '0) next_result = '1;
                    else         next_result = {{WIDTH{1'b0}}, quotient};
                end
                OP_MOD: begin
                    if (b == '0) next_result = a_ext;
                    else         next_result = {{WIDTH{1'b0}}, remainder};
                end
                OP_EQ:  next_result = {{(RW-1){1'b0}}, (a == b)};
                OP_GT:  next_result = {{(RW-1){1'b0}}, (a > b)};
                OP_LT:  next_result = {{(RW-1){1'b0}}, (a < b)};
                default: next_result = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= next_result;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with known answers, a random sweep
// scored against a behavioural model, and asynchronous reset checks.
module tb_alu;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [2:0]  opcode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] result;

    logic [15:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    alu #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .result (result)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] model(input logic en, input logic [2:0] op,
                                          input logic [7:0] x, input logic [7:0] y);
        logic [15:0] xe;
        logic [15:0] ye;
        xe = {8'h00, x};
        ye = {8'h00, y};
        if (!en) return 16'h0000;
        case (op)
            3'b000: return xe + ye;
            3'b001: return xe - ye;
            3'b010: return xe * ye;
            3'b011: return (y == 8'h00) ? 16'hFFFF : (xe / ye);
            3'b100: return (y == 8'h00) ? xe : (xe % ye);
            3'b101: return (x == y) ? 16'h0001 : 16'h0000;
            3'b110: return (x > y)  ? 16'h0001 : 16'h0000;
            default: return (x < y) ? 16'h0001 : 16'h0000;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Drive at the falling edge and record what the next rising edge must produce.
    task automatic drive(input logic en, input logic [2:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] exp);
        @(negedge clk);
        ena    = en;
        opcode = op;
        a      = x;
        b      = y;
        exp_q.push_back(exp);
    endtask

    // Sample 1 time unit after the rising edge and score the oldest expectation.
    task automatic collect(input string tag);
        logic [15:0] exp;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %h expected <empty queue>", tag, result);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, result, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic en, input logic [2:0] op,
                          input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
        drive(en, op, x, y, exp);
        collect(tag);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  op;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [0:NV-1] = '{
        '{3'b000, 8'h00, 8'h00, 16'h0000},
        '{3'b000, 8'h0F, 8'h05, 16'h0014},
        '{3'b000, 8'hFF, 8'h01, 16'h0100},
        '{3'b000, 8'h7F, 8'h7F, 16'h00FE},
        '{3'b001, 8'h0A, 8'h05, 16'h0005},
        '{3'b001, 8'h05, 8'h0A, 16'hFFFB},
        '{3'b001, 8'hFF, 8'hFF, 16'h0000},
        '{3'b010, 8'h00, 8'h05, 16'h0000},
        '{3'b010, 8'h05, 8'h06, 16'h001E},
        '{3'b010, 8'h0F, 8'h10, 16'h00F0},
        '{3'b010, 8'hFF, 8'hFF, 16'hFE01},
        '{3'b011, 8'h0A, 8'h02, 16'h0005},
        '{3'b011, 8'h0F, 8'h04, 16'h0003},
        '{3'b011, 8'hFF, 8'h01, 16'h00FF},
        '{3'b011, 8'h64, 8'h00, 16'hFFFF},
        '{3'b100, 8'h0A, 8'h03, 16'h0001},
        '{3'b100, 8'h0F, 8'h04, 16'h0003},
        '{3'b100, 8'h08, 8'h04, 16'h0000},
        '{3'b100, 8'h64, 8'h00, 16'h0064},
        '{3'b101, 8'h0A, 8'h0A, 16'h0001},
        '{3'b101, 8'hFA, 8'h0B, 16'h0000},
        '{3'b101, 8'hFF, 8'hFF, 16'h0001},
        '{3'b110, 8'h0B, 8'h0A, 16'h0001},
        '{3'b110, 8'h0A, 8'h0B, 16'h0000},
        '{3'b110, 8'h0A, 8'h0A, 16'h0000},
        '{3'b111, 8'h0A, 8'h0B, 16'h0001},
        '{3'b111, 8'h0B, 8'h0A, 16'h0000},
        '{3'b111, 8'h0A, 8'h0A, 16'h0000}
    };

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       ren;

        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        ena    = 1'b0;
        opcode = 3'b000;
        a      = 8'h00;
        b      = 8'h00;

        #1;
        check_eq("reset_value", result, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", result, 16'h0000);

        // Release with ena low: output stays zero even with nonzero operands.
        @(negedge clk);
        rst = 1'b0;
        run_op("ena_low", 1'b0, 3'b000, 8'h0F, 8'h05, 16'h0000);
        run_op("ena_low_mul", 1'b0, 3'b010, 8'hFF, 8'hFF, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d_op%0d", i, vecs[i].op), 1'b1,
                   vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].exp);
        end

        // Back-to-back opcode change on consecutive edges.
        run_op("b2b_mul", 1'b1, 3'b010, 8'hFF, 8'hFF, 16'hFE01);
        run_op("b2b_add", 1'b1, 3'b000, 8'hFF, 8'h01, 16'h0100);

        // Enabled result followed by disable returns to zero.
        run_op("ena_drop", 1'b0, 3'b010, 8'h05, 8'h06, 16'h0000);

        // Asynchronous reset between edges while a nonzero result is held.
        run_op("pre_rst", 1'b1, 3'b010, 8'hFF, 8'hFF, 16'hFE01);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst", result, 16'h0000);

        // An operation set up while reset is high is discarded.
        @(negedge clk);
        ena    = 1'b1;
        opcode = 3'b000;
        a      = 8'h0F;
        b      = 8'h05;
        @(posedge clk);
        #1;
        check_eq("rst_discard", result, 16'h0000);

        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 1'b1, 3'b001, 8'h05, 8'h0A, 16'hFFFB);

        // Random sweep scored against the model, back to back every cycle.
        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            ren = ($urandom_range(0, 9) != 0);
            run_op($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), ren, rop, ra, rb,
                   model(ren, rop, ra, rb));
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover_queue: got %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
